shifter_pipe: RTL
=================

Name: shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter; next generation of the 32-bit combinational shifter.
- Performs SLL, SRL and SRA, plus ROR when compiled in, on WIDTH-bit operands. Shift amount is log2(WIDTH) bits.
- Has a valid/ready handshake with full backpressure, register slices every REG_EVERY mux stages, and a tag passed alongside the data.
- Sits between the execute-stage issue logic and writeback in multi-cycle ALU paths.

Parameters:
- WIDTH, 32, operand width; power of two, 8..128.
- REG_EVERY, 2, mux stages per pipeline register; 1..log2(WIDTH).
- TAG_W, 4, width of sideband tag carried with each operation; >=1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- in_a  in  WIDTH  operand.
- in_shamt  in  $clog2(WIDTH)  shift amount.
- in_mode  in  2  00=SLL, 01=SRL, 10=SRA, 11=ROR/SRA (see Optional Feature).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_y  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.
- out_zero  out  1  out_y == 0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Shift network:
  - S = $clog2(WIDTH) log-shifter stages; stage k shifts by 2^k when in_shamt[k]=1.
  - Fill bits: 0 for SLL/SRL; the current MSB for SRA; wrapped-around bits for ROR.
  - Mode and shamt travel with the data through each register slice.
- Pipelining:
  - L = ceil(S/REG_EVERY) register slices. Slice j holds valid_j, data, shamt, mode and tag.
  - Latency: an accepted input appears on out_* exactly L cycles later if out_ready has been held high. Slice L-1 drives out_* directly from its registers.
  - Combinational stages between registers: at most REG_EVERY.
- Handshake:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - Per slice: advance_j = !valid_j || advance_{j+1}, with advance_L = out_ready.
  - in_ready = advance_0. It is combinational from out_ready, and this is the only comb path from out_* to in_*.
  - A slice loads from its predecessor when advance_j is true. The slice's valid takes the predecessor's valid; for slice 0, that is in_valid.
  - A stalled slice holds its contents stable. out_y and out_tag must not change while out_valid && !out_ready.
  - Full throughput: one op per cycle when out_ready stays high.
  - Capacity: L ops in flight. When all slices are valid and out_ready=0, in_ready=0.
  - Order preserved; no drop, no duplication.
  - Simultaneous input and output transfer on a full pipe is legal and keeps occupancy at L.
- Boundaries:
  - shamt=0 gives y=a in every mode.
  - shamt=WIDTH-1 gives the max shift; no wider shift is representable.
  - SRA of a negative operand by WIDTH-1 gives all ones.
  - in_valid=0 produces bubbles that occupy slices but are never presented.
- out_zero is computed combinationally from the final registered data and is valid only with out_valid.
- Reset:
  - rst_n low clears every valid bit, data register, tag register and out_zero immediately, independent of clk.
  - Reset values: out_valid=0, out_y=0, out_tag=0, out_zero=0. in_ready=1 when out_ready=1 or the pipe is empty; after reset the pipe is empty, so in_ready=1.
  - Reset mid-operation discards all in-flight ops. The first op accepted after deassertion emerges after exactly L cycles.
- in_mode 11 without the optional feature behaves as SRA.

Optional Feature:
- Macro: SHIFTER_PIPE_ROTATE_EN.
- Defined: in_mode=11 is rotate right; bits shifted out of the LSB re-enter at the MSB, per stage.
- Not defined: in_mode=11 is identical to 10 (SRA), and no rotate muxing logic is generated.

Test Plan:
- WIDTH=32, REG_EVERY=2 (L=3), out_ready=1. SLL a=0x00000001, shamt=31, tag=5 -> out_y=0x80000000, out_tag=5, out_valid exactly 3 cycles after acceptance.
- a=0x80000000, shamt=4: SRA -> 0xF8000000; SRL -> 0x08000000. Back-to-back issue -> results on consecutive cycles, in order.
- Mode 11, a=0x000000F1, shamt=4: with SHIFTER_PIPE_ROTATE_EN -> 0x1000000F; without -> 0x0000000F.
- Issue 5 ops with tags 1..5 and hold out_ready=0 for 6 cycles -> in_ready drops after 3 accepted; out_y/out_tag stay stable. Release -> tags emerge 1,2,3,4,5, none lost.
- SRL a=0x00000001, shamt=1 -> out_y=0, out_zero=1. shamt=0, a=0xDEADBEEF in each mode -> out_y=0xDEADBEEF, out_zero=0.
- Assert rst_n=0 mid-cycle with 3 ops in flight -> out_valid=0 immediately and no stale result appears after release. A new op emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/shifter_pipe.sv
// shifter_pipe -- pipelined, parametrised barrel shifter with valid/ready flow
// control and a sideband tag.
//
// Operations (in_mode): 00 SLL, 01 SRL, 10 SRA, 11 ROR when SHIFTER_PIPE_ROTATE_EN
// is defined, otherwise 11 is SRA.
//
// The log-shifter has S = $clog2(WIDTH) stages; stage k shifts by 2^k when
// shamt[k] is set. Stages are grouped REG_EVERY at a time in front of each of
// the L = ceil(S/REG_EVERY) register slices, so an accepted op reaches out_*
// L cycles later when downstream never stalls.
//
// Handshake: a transfer happens on any cycle where valid && ready are both high
// at the rising clock edge. A slice advances when it is empty or the slice
// after it advances; the last slice advances on out_ready. in_ready is the
// advance of slice 0, which is the only combinational path from out_ready.
// A stalled slice holds its contents, so out_y/out_tag are stable while
// out_valid && !out_ready.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   in_valid/in_ready        input handshake
//   in_a, in_shamt, in_mode  operand, shift amount, operation
//   in_tag                   sideband tag carried with the op
//   out_valid/out_ready      output handshake
//   out_y, out_tag           result and its tag (driven straight from the last slice)
//   out_zero                 out_y == 0, qualified by out_valid
//
// Build option: SHIFTER_PIPE_ROTATE_EN enables rotate-right for in_mode 11.
module shifter_pipe #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero
);

    localparam int S = $clog2(WIDTH);
    localparam int L = (S + REG_EVERY - 1) / REG_EVERY;

    logic [L-1:0]     valid_q;
    logic [WIDTH-1:0] data_q  [L];
    logic [S-1:0]     shamt_q [L];
    logic [1:0]       mode_q  [L];
    logic [TAG_W-1:0] tag_q   [L];
    logic [L-1:0]     adv;

    // One log-shifter stage: shift by 2^k with the fill rule of the mode.
    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                     input int k,
                                                     input logic [1:0] mode);
        int amt;
        amt = 1 << k;
        case (mode)
            2'b00:   return d << amt;
            2'b01:   return d >> amt;
`ifdef SHIFTER_PIPE_ROTATE_EN
            2'b11:   return (d >> amt) | (d << (WIDTH - amt));
`endif
            default: return $signed(d) >>> amt;
        endcase
    endfunction

    for (genvar j = 0; j < L; j++) begin : g_slice
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic [S-1:0]     src_shamt;
        logic [1:0]       src_mode;
        logic [TAG_W-1:0] src_tag;
        logic [WIDTH-1:0] stage_data;

        if (j == 0) begin : g_first
            assign src_valid = in_valid;
            assign src_data  = in_a;
            assign src_shamt = in_shamt;
            assign src_mode  = in_mode;
            assign src_tag   = in_tag;
        end else begin : g_next
            assign src_valid = valid_q[j-1];
            assign src_data  = data_q[j-1];
            assign src_shamt = shamt_q[j-1];
            assign src_mode  = mode_q[j-1];
            assign src_tag   = tag_q[j-1];
        end

        // Stages j*REG_EVERY .. up to REG_EVERY of them, clipped at S.
        always_comb begin
            stage_data = src_data;
            for (int k = j * REG_EVERY; k < S && k < (j + 1) * REG_EVERY; k++) begin
                if (src_shamt[k]) stage_data = shift_stage(stage_data, k, src_mode);
            end
        end

        // Equivalent to !valid_j || advance_{j+1} unrolled: the slice moves if
        // downstream accepts or any slice from here to the output has a hole.
        assign adv[j] = out_ready | ~(&valid_q[L-1:j]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q[j] <= 1'b0;
                data_q[j]  <= '0;
                shamt_q[j] <= '0;
                mode_q[j]  <= '0;
                tag_q[j]   <= '0;
            end else if (adv[j]) begin
                valid_q[j] <= src_valid;
                data_q[j]  <= stage_data;
                shamt_q[j] <= src_shamt;
                mode_q[j]  <= src_mode;
                tag_q[j]   <= src_tag;
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[L-1];
    assign out_y     = data_q[L-1];
    assign out_tag   = tag_q[L-1];
    assign out_zero  = valid_q[L-1] && (data_q[L-1] == '0);

endmodule
